pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central stall/flush controller for the 5-stage RISC-V pipeline. Collects stall requests from IF, ID and MEM and the branch-mispredict report from EX, and produces the stall vector and flush strobe consumed by every inter-stage register and the PC register. Mispredicts that arrive while the pipeline is frozen are held and replayed. Instruction fetches still in flight at redirect time are tracked and their results discarded.

## Interface
Parameters:
- DEPTH, 6: stall vector width; bit 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 reserved (always 0).
- ADDR_W, 32: PC width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- if_stall_req  in  1  IF waiting on memory.
- id_stall_req  in  1  load-use hazard.
- mem_stall_req  in  1  MEM waiting on memory.
- ex_mispredict  in  1  EX resolved branch/jump against prediction; single-cycle pulse.
- ex_target  in  ADDR_W  correct next PC, valid with ex_mispredict.
- if_busy  in  1  IF has an outstanding memory fetch.
- if_done  in  1  outstanding fetch returns this cycle.
- stall  out  DEPTH  per-register hold; bit i=1 with bit i+1=0 makes register i+1 load a bubble.
- flush  out  1  kill IF/ID and ID/EX contents.
- redirect  out  1  PC loads redirect_pc.
- redirect_pc  out  ADDR_W  redirect target.
- if_discard  out  1  IF drops the returning fetch data.

## Operation
- Stall vector (combinational, priority MEM > ID > IF):
  - mem_stall_req: 011111.
  - else id_stall_req: 000111.
  - else if_stall_req: 000011.
  - else 000000.
- FSM states:
  - IDLE
  - HOLD: mispredict latched during a MEM stall.
  - DISCARD: stale fetch in flight.
- IDLE:
  - ex_mispredict with mem_stall_req=0: issue redirect now (flush=1, redirect=1, redirect_pc=ex_target). Then go to DISCARD if if_busy=1 and if_done=0; otherwise stay in IDLE.
  - ex_mispredict with mem_stall_req=1: latch ex_target into pend_pc and go to HOLD. No flush this cycle.
- HOLD:
  - Outputs stay quiet while mem_stall_req=1.
  - In the first cycle with mem_stall_req=0: flush=1, redirect=1, redirect_pc=pend_pc, then apply the same DISCARD test as IDLE.
  - Any ex_mispredict while in HOLD is ignored; EX is frozen, so none is legal.
- DISCARD:
  - if_discard=1 and stall[0]=1, so the PC holds the redirected value.
  - Exit to IDLE in the cycle if_done=1; if_discard is still 1 in that cycle.
- Flush overrides ID/IF stall in its cycle: stall forced to 000000 except bit 0, which follows the DISCARD rule.
- redirect_pc is 0 whenever redirect=0.

## Timing
- Stall, flush and redirect are combinational from inputs and state; zero-cycle latency.
- Redirect delay for a latched mispredict equals the remaining MEM stall length. The first free cycle carries the flush.
- Reset values: stall=0, flush=0, redirect=0, redirect_pc=0, if_discard=0, state=IDLE, pend_pc=0.
- Reset asserted mid-HOLD or mid-DISCARD abandons the pending redirect or discard. All outputs read 0 in the cycle following the reset edge.
- ex_mispredict and if_done in the same IDLE cycle: redirect issues and no DISCARD is entered (the fetch completed before the redirect).
- if_busy=0 at redirect: no DISCARD.

## Configuration
- PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cycles, perf_flushes and perf_discards (32-bit each, wrap at 2^32, reset 0).
  - perf_stall_cycles increments on each cycle with any stall bit set.
  - perf_flushes increments per flush pulse.
  - perf_discards increments per DISCARD entry.
- Undefined: ports and counters are absent; the rest of the behaviour is identical.

## Test plan
- Priority: mem_stall_req=1 and id_stall_req=1 together -> stall=011111. id_stall_req alone -> 000111. if_stall_req alone -> 000011.
- Free mispredict: ex_mispredict=1, ex_target=0x1000, if_busy=0 -> same cycle flush=1, redirect=1, redirect_pc=0x1000. Next cycle all 0, state IDLE.
- Held mispredict: mispredict target 0x2000 during a 3-cycle MEM stall -> flush=0 for those cycles. Flush=1 with redirect_pc=0x2000 in the first cycle after mem_stall_req falls.
- Discard: mispredict with if_busy=1, then if_done after 4 cycles -> if_discard=1 and stall[0]=1 for 4 cycles after the redirect. Cleared the cycle after if_done.
- Reset in HOLD: rst pulse while holding target 0x3000, then mem_stall_req drops -> no flush or redirect ever issued.
- With PIPE_CTRL_PERF_EN defined: 5 stall cycles and 2 flushes (one with discard) -> perf_stall_cycles=5, perf_flushes=2, perf_discards=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall/flush controller for the 5-stage RISC-V pipeline.
//
// Merges the IF/ID/MEM stall requests into one per-register hold vector.
// It also turns the EX branch-mispredict report into a one-cycle flush/redirect
// strobe. A mispredict that arrives during a MEM stall is held and replayed in
// the first free cycle. A fetch still in flight at redirect time is tracked
// until it returns, so IF can drop its data.
//
// Optional feature: define PIPE_CTRL_PERF_EN to add the 32-bit performance
// counters perf_stall_cycles, perf_flushes and perf_discards.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   if_stall_req     IF waiting on memory
//   id_stall_req     load-use hazard
//   mem_stall_req    MEM waiting on memory
//   ex_mispredict    single-cycle mispredict pulse from EX
//   ex_target        correct next PC, valid with ex_mispredict
//   if_busy          IF has an outstanding fetch
//   if_done          outstanding fetch returns this cycle
//   stall            per-register hold (0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB)
//   flush            kill IF/ID and ID/EX contents
//   redirect         PC loads redirect_pc
//   redirect_pc      redirect target (0 when redirect=0)
//   if_discard       IF drops the returning fetch data
//   perf_*           (PIPE_CTRL_PERF_EN only) wrapping event counters
module pipe_ctrl #(
  parameter int unsigned DEPTH  = 6,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              mem_stall_req,
  input  logic              ex_mispredict,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              if_busy,
  input  logic              if_done,
  output logic [DEPTH-1:0]  stall,
  output logic              flush,
  output logic              redirect,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              if_discard
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles,
  output logic [31:0]       perf_flushes,
  output logic [31:0]       perf_discards
`endif
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HOLD    = 2'd1;
  localparam logic [1:0] ST_DISCARD = 2'd2;

  // Hold patterns: a stalled stage also holds everything upstream of it, and
  // the first un-held register downstream loads a bubble.
  localparam logic [DEPTH-1:0] STALL_MEM = DEPTH'(5'b11111);
  localparam logic [DEPTH-1:0] STALL_ID  = DEPTH'(5'b00111);
  localparam logic [DEPTH-1:0] STALL_IF  = DEPTH'(5'b00011);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              fire;
  logic [ADDR_W-1:0] fire_pc;
  logic [DEPTH-1:0]  stall_c;

  // Next state and redirect decision
  always_comb begin
    state_d   = state_q;
    pend_pc_d = pend_pc_q;
    fire      = 1'b0;
    fire_pc   = '0;
    case (state_q)
      ST_IDLE: begin
        if (ex_mispredict) begin
          if (!mem_stall_req) begin
            fire    = 1'b1;
            fire_pc = ex_target;
          end else begin
            pend_pc_d = ex_target;
            state_d   = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // EX is frozen here, so any ex_mispredict is spurious and ignored.
        if (!mem_stall_req) begin
          fire    = 1'b1;
          fire_pc = pend_pc_q;
        end
      end
      ST_DISCARD: begin
        if (if_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fetch returning in the redirect cycle already belongs to the old path
    // and is consumed then, so only a fetch still outstanding needs tracking.
    if (fire) state_d = (if_busy && !if_done) ? ST_DISCARD : ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Stall vector; the flush cycle lets every register load so the bubbles and
  // the new PC go in, while DISCARD pins the PC on the redirected value.
  always_comb begin
    if (mem_stall_req)     stall_c = STALL_MEM;
    else if (id_stall_req) stall_c = STALL_ID;
    else if (if_stall_req) stall_c = STALL_IF;
    else                   stall_c = '0;
    if (fire) stall_c = '0;
    if (state_q == ST_DISCARD) stall_c[0] = 1'b1;
  end

  // Outputs are gated during reset so they read their reset values.
  assign stall       = rst ? '0 : stall_c;
  assign flush       = fire & ~rst;
  assign redirect    = fire & ~rst;
  assign redirect_pc = (fire && !rst) ? fire_pc : '0;
  assign if_discard  = (state_q == ST_DISCARD) && !rst;

`ifdef PIPE_CTRL_PERF_EN
  logic discard_entry;
  assign discard_entry = (state_d == ST_DISCARD) && (state_q != ST_DISCARD);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
      perf_discards     <= '0;
    end else begin
      if (|stall)        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush)         perf_flushes      <= perf_flushes + 32'd1;
      if (discard_entry) perf_discards     <= perf_discards + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl. Inputs change 1 time unit after
// the rising edge; combinational outputs are sampled 2 units later.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, mem_stall_req;
  logic        ex_mispredict;
  logic [31:0] ex_target;
  logic        if_busy, if_done;
  logic [5:0]  stall;
  logic        flush, redirect, if_discard;
  logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles, perf_flushes, perf_discards;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.DEPTH(6), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall_req  (if_stall_req),
    .id_stall_req  (id_stall_req),
    .mem_stall_req (mem_stall_req),
    .ex_mispredict (ex_mispredict),
    .ex_target     (ex_target),
    .if_busy       (if_busy),
    .if_done       (if_done),
    .stall         (stall),
    .flush         (flush),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .if_discard    (if_discard)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flushes      (perf_flushes),
    .perf_discards     (perf_discards)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock, leaving inputs free to change just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic quiet();
    if_stall_req  = 1'b0;
    id_stall_req  = 1'b0;
    mem_stall_req = 1'b0;
    ex_mispredict = 1'b0;
    ex_target     = 32'h0;
    if_busy       = 1'b0;
    if_done       = 1'b0;
  endtask

  task automatic check_all(input string tag, input logic [5:0] s, input logic f,
                           input logic [31:0] pc, input logic d);
    check({tag, ".stall"}, 64'(stall), 64'(s));
    check({tag, ".flush"}, 64'(flush), 64'(f));
    check({tag, ".redirect"}, 64'(redirect), 64'(f));
    check({tag, ".redirect_pc"}, 64'(redirect_pc), 64'(pc));
    check({tag, ".if_discard"}, 64'(if_discard), 64'(d));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    settle();
    check_all("reset", 6'b000000, 1'b0, 32'h0, 1'b0);

    // Stall priority
    mem_stall_req = 1'b1; id_stall_req = 1'b1; settle();
    check("prio_mem_id", 64'(stall), 64'(6'b011111));
    mem_stall_req = 1'b0; settle();
    check("prio_id", 64'(stall), 64'(6'b000111));
    id_stall_req = 1'b0; if_stall_req = 1'b1; settle();
    check("prio_if", 64'(stall), 64'(6'b000011));
    mem_stall_req = 1'b1; settle();
    check("prio_mem_if", 64'(stall), 64'(6'b011111));
    quiet(); settle();
    check("prio_none", 64'(stall), 64'(6'b000000));
    tick();

    // Free mispredict
    ex_mispredict = 1'b1; ex_target = 32'h1000; settle();
    check_all("free", 6'b000000, 1'b1, 32'h1000, 1'b0);
    tick(); quiet(); settle();
    check_all("free_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    tick();

    // Flush overrides an ID stall in its cycle
    ex_mispredict = 1'b1; ex_target = 32'h1234; id_stall_req = 1'b1; settle();
    check_all("flush_ovr", 6'b000000, 1'b1, 32'h1234, 1'b0);
    tick(); quiet(); settle();
    check_all("flush_ovr_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    tick();

    // Held mispredict across a 3-cycle MEM stall; a stray pulse in HOLD is ignored
    mem_stall_req = 1'b1; ex_mispredict = 1'b1; ex_target = 32'h2000; settle();
    check_all("hold_c0", 6'b011111, 1'b0, 32'h0, 1'b0);
    tick(); ex_mispredict = 1'b1; ex_target = 32'h9999; settle();
    check_all("hold_c1", 6'b011111, 1'b0, 32'h0, 1'b0);
    tick(); ex_mispredict = 1'b0; ex_target = 32'h0; settle();
    check_all("hold_c2", 6'b011111, 1'b0, 32'h0, 1'b0);
    tick(); mem_stall_req = 1'b0; settle();
    check_all("hold_fire", 6'b000000, 1'b1, 32'h2000, 1'b0);
    tick(); settle();
    check_all("hold_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    tick();

    // Discard: redirect with fetch in flight, fetch returns 4 cycles later
    ex_mispredict = 1'b1; ex_target = 32'h4000; if_busy = 1'b1; settle();
    check_all("disc_fire", 6'b000000, 1'b1, 32'h4000, 1'b0);
    tick(); ex_mispredict = 1'b0; ex_target = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      settle();
      check_all($sformatf("disc_c%0d", i), 6'b000001, 1'b0, 32'h0, 1'b1);
      tick();
    end
    if_done = 1'b1; settle();
    check_all("disc_done", 6'b000001, 1'b0, 32'h0, 1'b1);
    tick(); quiet(); settle();
    check_all("disc_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    tick();

    // MEM stall during DISCARD keeps its own pattern with the PC held
    ex_mispredict = 1'b1; ex_target = 32'h4400; if_busy = 1'b1; settle();
    tick(); ex_mispredict = 1'b0; mem_stall_req = 1'b1; settle();
    check("disc_mem", 64'(stall), 64'(6'b011111));
    check("disc_mem_d", 64'(if_discard), 64'(1'b1));
    if_done = 1'b1; tick(); quiet(); settle();
    check("disc_mem_after", 64'(if_discard), 64'(1'b0));
    tick();

    // Mispredict and if_done together: no DISCARD
    ex_mispredict = 1'b1; ex_target = 32'h5000; if_busy = 1'b1; if_done = 1'b1; settle();
    check_all("same_done", 6'b000000, 1'b1, 32'h5000, 1'b0);
    tick(); quiet(); settle();
    check_all("same_done_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    tick();

    // Reset while holding 0x3000 abandons the redirect
    mem_stall_req = 1'b1; ex_mispredict = 1'b1; ex_target = 32'h3000; settle();
    check("rhold_pre", 64'(flush), 64'(1'b0));
    tick(); ex_mispredict = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0; mem_stall_req = 1'b0; settle();
    check_all("rhold_c0", 6'b000000, 1'b0, 32'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick(); settle();
      check_all($sformatf("rhold_c%0d", i), 6'b000000, 1'b0, 32'h0, 1'b0);
    end
    tick();

    // Reset while discarding clears if_discard
    ex_mispredict = 1'b1; ex_target = 32'h6000; if_busy = 1'b1; settle();
    tick(); ex_mispredict = 1'b0; settle();
    check("rdisc_pre", 64'(if_discard), 64'(1'b1));
    rst = 1'b1; tick(); rst = 1'b0; settle();
    check_all("rdisc_after", 6'b000000, 1'b0, 32'h0, 1'b0);
    tick();

`ifdef PIPE_CTRL_PERF_EN
    // 3 ID stall cycles + free flush + flush into 2 DISCARD cycles (PC held)
    do_reset();
    id_stall_req = 1'b1;
    tick(); tick(); tick();
    quiet(); ex_mispredict = 1'b1; ex_target = 32'h7000;
    tick();
    ex_mispredict = 1'b1; ex_target = 32'h8000; if_busy = 1'b1;
    tick();
    ex_mispredict = 1'b0;
    tick();
    if_done = 1'b1;
    tick();
    quiet(); tick(); settle();
    check("perf_stall_cycles", 64'(perf_stall_cycles), 64'd5);
    check("perf_flushes", 64'(perf_flushes), 64'd2);
    check("perf_discards", 64'(perf_discards), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
